chroma_subsample_8x8: RTL and testbench
=======================================

Name: chroma_subsample_8x8

Overview:
- Encoder-side chroma downsampler for 4:2:0: converts one 8x8 Cb or Cr block into a 4x4 block by rounded 2x2 averaging.
- Accepts the 8x8 block one row per cycle over a valid/ready handshake.
- Holds the finished 4x4 block until the downstream stage accepts it.
- Sits between the colour-conversion/block-split stage and the chroma DCT path. Luma (Y) blocks are consumed and discarded.

Parameters:
- PIX_W, 8, pixel width in bits.
- CH, from sys_defs.svh, highest channel index; ch encoding is Y=0, Cb=1, Cr=2.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- ch  input  $clog2(CH+1)  channel of incoming block, sampled on row 0 only
- in_valid  input  1  row_in holds a valid row
- in_ready  output  1  block accepts a row this cycle
- row_in  input  [7:0][PIX_W-1:0]  one 8-pixel row, index 0 = leftmost
- out_valid  output  1  block_out holds a complete 4x4 block
- out_ready  input  1  downstream accepts block_out
- block_out  output  [3:0][3:0][PIX_W-1:0]  subsampled block, [row][col]
- out_ch  output  $clog2(CH+1)  channel latched from row 0
- drop  output  1  one-cycle pulse when a non-chroma block has been fully consumed

Behaviour:
- Reset (asserted asynchronously):
  - State = COLLECT, row counter = 0.
  - in_ready = 1, out_valid = 0, drop = 0, out_ch = 0.
  - Even-row buffer and block_out = all zeros.
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
  - FULL: in_ready = 0, out_valid = 1.
- Row transfer:
  - A transfer occurs when in_valid && in_ready.
  - The 3-bit row counter increments per transfer and wraps 7 -> 0.
  - No transfer means no state change.
- Row 0 transfer: latch ch into out_ch, and into the internal chroma flag (flag = ch is 1 or 2).
- Even row r transfer (r = 0, 2, 4, 6): store row_in into the 8-pixel even-row buffer.
- Odd row r transfer (r = 1, 3, 5, 7): for j = 0..3, compute
  - block_out[r>>1][j] = (even[2j] + even[2j+1] + row_in[2j] + row_in[2j+1] + 2) >> 2
  - Sum is formed at PIX_W+2 bits. The result always fits PIX_W bits, so no saturation is needed.
  - block_out rows are written in place as odd rows arrive.
- On the row 7 transfer:
  - Chroma flag set: next state FULL. out_valid rises the cycle after the row 7 handshake, giving latency 1 cycle from the last row.
  - Chroma flag clear: remain in COLLECT, drop = 1 for exactly the next cycle, out_valid stays 0. block_out contents are don't-care for Y blocks.
- FULL:
  - block_out and out_ch are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, next state is COLLECT and in_ready returns to 1 the following cycle.
  - There is no same-cycle accept-and-refill; minimum block period is 9 cycles.
- ch is ignored on rows 1-7. Channel changes mid-block have no effect.
- in_valid in FULL is ignored; no row is consumed.
- Reset mid-block discards the partial block; the counter restarts at row 0.
- Reset in FULL drops the pending block; out_valid goes to 0 immediately (asynchronous).
- All outputs are registers or decodes of state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release -> in_ready=1, out_valid=0, drop=0, block_out all 0.
- Cb block, all pixels=100, ch=1, in_valid every cycle -> out_valid rises 1 cycle after row 7; every block_out entry = 100; out_ch=1; in_ready=0 until out_ready.
- Rounding/max: Cr block with 2x2 groups {255,255,255,255} -> 255, {1,2,2,2} -> 2 (7+2=9>>2), {0,0,0,1} -> 0, {0,0,1,1} -> 1 -> exact values at the matching block_out positions.
- Backpressure: complete a Cb block, hold out_ready=0 for 5 cycles while in_valid=1 with new data -> block_out unchanged, no rows consumed; out_ready=1 one cycle -> out_valid=0 and in_ready=1 next cycle; next block starts at row 0.
- Y block: ch=0 on row 0, ch=1 on rows 1-7 -> no out_valid; drop=1 for one cycle after row 7; next Cb block processed normally.
- Mid-block reset: feed 5 rows of a Cb block, assert reset_n=0 for 1 cycle, then feed a full 8-row Cr block with gaps in in_valid -> output reflects only the Cr data, out_ch=2.

Source files
------------

// File: rtl/chroma_subsample_8x8.sv
// chroma_subsample_8x8
// Encoder-side 4:2:0 chroma downsampler. Takes one 8x8 Cb/Cr block one row
// per cycle and produces a 4x4 block of rounded 2x2 averages. The finished
// block is held until the downstream stage accepts it. Luma blocks are
// consumed in full and discarded, with a one-cycle drop pulse at the end.
//
// Timing summary:
//   - rows 0..7 are accepted on in_valid && in_ready (in_ready = COLLECT)
//   - out_valid rises the cycle after the row 7 handshake of a chroma block
//   - the block is released on out_valid && out_ready; in_ready returns the
//     cycle after, so the minimum block period is 9 cycles
//   - every output is a register or a decode of the state register

module chroma_subsample_8x8 #(
  parameter int PIX_W = 8,
  // Highest channel index (Y=0, Cb=1, Cr=2); system builds keep this in step
  // with the shared channel definitions.
  parameter int CH    = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [$clog2(CH+1)-1:0]           ch,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [7:0][PIX_W-1:0]             row_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0][3:0][PIX_W-1:0]        block_out,
  output logic [$clog2(CH+1)-1:0]           out_ch,
  output logic                              drop
);

  localparam int CH_W  = $clog2(CH + 1);
  // Four PIX_W pixels plus the rounding constant fit in PIX_W+2 bits.
  localparam int SUM_W = PIX_W + 2;

  localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
  localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [2:0]              row_cnt_q;
  logic                    chroma_q;
  logic [7:0][PIX_W-1:0]   even_buf_q;

  logic                    row_xfer;
  logic                    first_row;
  logic                    last_row;
  logic                    odd_row;
  logic                    ch_is_chroma;
  logic [SUM_W-1:0]        pair_sum [4];
  logic [3:0][PIX_W-1:0]   avg_row;

  // Handshake and row-position decodes shared by the datapath and the FSM.
  assign row_xfer     = in_valid && in_ready;
  assign first_row    = (row_cnt_q == 3'd0);
  assign last_row     = (row_cnt_q == 3'd7);
  assign odd_row      = row_cnt_q[0];
  assign ch_is_chroma = (ch == CH_CB) || (ch == CH_CR);

  // FSM state register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded handshake outputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        // Only a chroma block becomes visible; a luma block falls through
        // and stays in COLLECT.
        if (row_xfer && last_row && chroma_q) begin
          state_d = FULL;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        // No refill in the accept cycle: in_ready returns one cycle later.
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Row counter: advances once per accepted row and wraps 7 -> 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt_q <= 3'd0;
    end else if (row_xfer) begin
      row_cnt_q <= row_cnt_q + 3'd1;
    end
  end

  // Channel capture on row 0; ch on later rows is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_ch   <= '0;
      chroma_q <= 1'b0;
    end else if (row_xfer && first_row) begin
      out_ch   <= ch;
      chroma_q <= ch_is_chroma;
    end
  end

  // Even-row buffer: keeps the upper row of each vertical pixel pair.
  // NOTE: this pixel storage is cleared by reset so a freshly reset block
  // reads as zeros; the datapath itself never depends on the cleared value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      even_buf_q <= '0;
    end else if (row_xfer && !odd_row) begin
      even_buf_q <= row_in;
    end
  end

  // Rounded 2x2 average of the buffered even row and the incoming odd row.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      pair_sum[j] = SUM_W'(even_buf_q[2*j])
                  + SUM_W'(even_buf_q[2*j+1])
                  + SUM_W'(row_in[2*j])
                  + SUM_W'(row_in[2*j+1])
                  + SUM_W'(2);
      // The maximum (4*max+2)>>2 equals max, so the quotient needs no clamp.
      avg_row[j]  = pair_sum[j][SUM_W-1:2];
    end
  end

  // Output block: each odd row writes its output row in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      block_out <= '0;
    end else if (row_xfer && odd_row) begin
      block_out[row_cnt_q[2:1]] <= avg_row;
    end
  end

  // Drop pulse: one cycle after the last row of a luma block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop <= 1'b0;
    end else begin
      drop <= row_xfer && last_row && !chroma_q;
    end
  end

endmodule

// File: tb/tb_chroma_subsample_8x8.sv
// tb_chroma_subsample_8x8
// Directed bench for chroma_subsample_8x8. A block-level model collects the
// accepted rows as a plain 8x8 array and averages the whole block once it is
// complete; a negedge compare process checks every output against it each
// cycle, and hand-computed literals pin the model in each scenario.

module tb_chroma_subsample_8x8;

  localparam int PIX_W = 8;
  localparam int CH    = 2;

  typedef logic [7:0][PIX_W-1:0]      row_t;
  typedef logic [3:0][3:0][PIX_W-1:0] blk4_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ch;
  logic        in_valid;
  logic        in_ready;
  row_t        row_in;
  logic        out_valid;
  logic        out_ready;
  blk4_t       block_out;
  logic [1:0]  out_ch;
  logic        drop;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  chroma_subsample_8x8 #(.PIX_W(PIX_W), .CH(CH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ch        (ch),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_in    (row_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_out (block_out),
    .out_ch    (out_ch),
    .drop      (drop)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- block-level model ----------------
  row_t       m_pix [8];
  int         m_rows   = 0;
  bit         m_full   = 1'b0;
  bit         m_chroma = 1'b0;
  bit         m_drop   = 1'b0;
  logic [1:0] m_ch     = 2'd0;
  blk4_t      m_exp    = '0;

  function automatic blk4_t avg_block(input row_t p [8]);
    blk4_t res;
    int    s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = int'(p[2*r][2*c]) + int'(p[2*r][2*c+1])
          + int'(p[2*r+1][2*c]) + int'(p[2*r+1][2*c+1]);
        res[r][c] = PIX_W'((s + 2) / 4);
      end
    end
    return res;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rows   = 0;
      m_full   = 1'b0;
      m_chroma = 1'b0;
      m_drop   = 1'b0;
      m_ch     = 2'd0;
    end else begin
      m_drop = 1'b0;
      if (m_full) begin
        if (out_ready) m_full = 1'b0;
      end else if (in_valid) begin
        if (m_rows == 0) begin
          m_ch     = ch;
          m_chroma = (ch == 2'd1) || (ch == 2'd2);
        end
        m_pix[m_rows] = row_in;
        m_rows++;
        if (m_rows == 8) begin
          m_rows = 0;
          if (m_chroma) begin
            m_full = 1'b1;
            m_exp  = avg_block(m_pix);
          end else begin
            m_drop = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready", in_ready, !m_full);
      check("out_valid", out_valid, m_full);
      check("drop", drop, m_drop);
      check("out_ch", out_ch, m_ch);
      if (m_full) check("block_out", block_out, m_exp);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_row(input row_t r, input logic [1:0] c);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    row_in   = r;
    ch       = c;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      ok = in_ready;
      step();
      if (ok) break;
    end
    if (!ok) check("row_accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input row_t p [8], input logic [1:0] c0,
                            input logic [1:0] crest, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      send_row(p[r], (r == 0) ? c0 : crest);
      if (gaps && (r % 2 == 0)) step();
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  row_t  blk [8];
  row_t  tmp;
  blk4_t all100;

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ch        = 2'd0;
    row_in    = '0;
    for (int i = 0; i < 16; i++) all100[i/4][i%4] = 8'd100;

    // Reset held for 3 cycles, then idle.
    step();
    cmp_en = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_drop", drop, 1'b0);
    check("rst_block_out", block_out, 128'd0);
    check("rst_out_ch", out_ch, 2'd0);
    step();

    // Cb block, all pixels 100, back-to-back rows.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'd100;
    send_block(blk, 2'd1, 2'd1, 1'b0);
    check("cb_valid_lat1", out_valid, 1'b1);
    check("cb_all100", block_out, all100);
    check("cb_out_ch", out_ch, 2'd1);
    check("cb_in_ready_low", in_ready, 1'b0);
    repeat (3) step();
    check("cb_hold_in_ready", in_ready, 1'b0);
    accept();
    check("cb_release_valid", out_valid, 1'b0);
    check("cb_release_ready", in_ready, 1'b1);

    // Cr block exercising rounding and the maximum value.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'(r * 16 + c);
    tmp = '0; tmp[0] = 8'd255; tmp[1] = 8'd255; tmp[2] = 8'd1; tmp[3] = 8'd2;
    blk[0] = tmp;
    tmp = '0; tmp[0] = 8'd255; tmp[1] = 8'd255; tmp[2] = 8'd2; tmp[3] = 8'd2;
    tmp[5] = 8'd1; tmp[6] = 8'd1; tmp[7] = 8'd1;
    blk[1] = tmp;
    send_block(blk, 2'd2, 2'd2, 1'b0);
    check("rnd_max255", block_out[0][0], 8'd255);
    check("rnd_1222", block_out[0][1], 8'd2);
    check("rnd_0001", block_out[0][2], 8'd0);
    check("rnd_0011", block_out[0][3], 8'd1);
    check("rnd_out_ch", out_ch, 2'd2);
    accept();

    // Backpressure: block held while new rows are offered.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'(255 - (r * 8 + c));
    send_block(blk, 2'd1, 2'd1, 1'b0);
    in_valid = 1'b1;
    ch       = 2'd2;
    for (int c = 0; c < 8; c++) row_in[c] = 8'd7;
    repeat (5) step();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_block_held", block_out[0][0], 8'd251);
    check("bp_out_ch_held", out_ch, 2'd1);
    in_valid = 1'b0;
    accept();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    // Next block must start at row 0: per-row ramp gives 20*i+5 per row i.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'(r * 10);
    send_block(blk, 2'd2, 2'd2, 1'b0);
    check("bp_next_r0", block_out[0][0], 8'd5);
    check("bp_next_r3", block_out[3][1], 8'd65);
    check("bp_next_ch", out_ch, 2'd2);
    accept();

    // Luma block: consumed, dropped, never presented.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'd77;
    send_block(blk, 2'd0, 2'd1, 1'b0);
    check("y_drop_pulse", drop, 1'b1);
    check("y_no_valid", out_valid, 1'b0);
    check("y_in_ready", in_ready, 1'b1);
    step();
    check("y_drop_one_cycle", drop, 1'b0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'd100;
    send_block(blk, 2'd1, 2'd1, 1'b0);
    check("y_next_cb_valid", out_valid, 1'b1);
    check("y_next_cb_data", block_out, all100);
    accept();

    // Mid-block reset, then a Cr block with gaps in in_valid.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'd9;
    for (int r = 0; r < 5; r++) send_row(blk[r], 2'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'((r * 8 + c) * 3);
    send_block(blk, 2'd2, 2'd2, 1'b1);
    check("mr_valid", out_valid, 1'b1);
    check("mr_out_ch", out_ch, 2'd2);
    check("mr_first", block_out[0][0], 8'd14);
    check("mr_last", block_out[3][3], 8'd176);

    // Reset while FULL drops the pending block immediately.
    #2;
    reset_n = 1'b0;
    #1;
    check("full_rst_valid", out_valid, 1'b0);
    check("full_rst_ready", in_ready, 1'b1);
    step();
    reset_n = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
